// File: rtl/adc_channel_decimator.sv
// adc_channel_decimator
// Four-channel boxcar decimator for the fast-ADC front end. Each channel sums
// blocks of 2^k signed 16-bit samples and emits sum >>> k through a
// valid/ready output register. Results that cannot be stored because the
// consumer is stalled are discarded and counted in a saturating drop counter.
//
// Build option: define ADC_DECIM_ROUND_EN to add 2^(k-1) before the shift
// (round half up) and saturate the result to the 16-bit signed range.
// Without it the shift truncates toward -inf and no saturation is needed.
module adc_channel_decimator #(
  parameter int LOG2_DECIM_MAX = 10,
  parameter int DROP_CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  adc_ready,
  input  logic [3:0]            decim_log2,
  input  logic                  in_valid,
  input  logic [15:0]           in_A_data,
  input  logic [15:0]           in_B_data,
  input  logic [15:0]           in_C_data,
  input  logic [15:0]           in_D_data,
  output logic [15:0]           out_A_data,
  output logic [15:0]           out_B_data,
  output logic [15:0]           out_C_data,
  output logic [15:0]           out_D_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DROP_CNT_W-1:0] drop_count
);

  // Accumulator keeps LOG2_DECIM_MAX bits of headroom above the sample width.
  localparam int         ACC_W = 16 + LOG2_DECIM_MAX;
  localparam int         CNT_W = (LOG2_DECIM_MAX > 0) ? LOG2_DECIM_MAX : 1;
  localparam logic [3:0] K_MAX = 4'(LOG2_DECIM_MAX);

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  state_t                  state_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic [3:0]              k_reg;
  logic                    out_valid_reg;
  logic [DROP_CNT_W-1:0]   drop_count_reg;
  logic [15:0]             out_data_reg [4];

  logic [15:0]             in_data  [4];
  logic [15:0]             result_w [4];

  logic                    accept;
  logic                    block_start;
  logic                    block_end;
  logic                    load_out;
  logic [3:0]              k_clip;
  logic [3:0]              k_cur;
  logic [CNT_W:0]          span;
  logic [CNT_W:0]          cnt_plus1;

  assign in_data[0] = in_A_data;
  assign in_data[1] = in_B_data;
  assign in_data[2] = in_C_data;
  assign in_data[3] = in_D_data;

  // A sample is taken whenever the front end is ready and strobes valid.
  assign accept      = adc_ready && in_valid;
  // Counter is held at zero in IDLE, so either term marks the first sample.
  assign block_start = (state_reg == IDLE) || (cnt_reg == '0);
  assign k_clip      = (decim_log2 > K_MAX) ? K_MAX : decim_log2;
  // The ratio is latched on the first sample; later changes wait for the next block.
  assign k_cur       = block_start ? k_clip : k_reg;
  assign span        = {{CNT_W{1'b0}}, 1'b1} << k_cur;
  assign cnt_plus1   = {1'b0, cnt_reg} + {{CNT_W{1'b0}}, 1'b1};
  assign block_end   = accept && (cnt_plus1 == span);
  // A stalled output keeps its word unless it is consumed in this same cycle.
  assign load_out    = block_end && (!out_valid_reg || out_ready);

  // Per-channel accumulator and result datapath
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : gen_ch
      logic signed [ACC_W-1:0] acc_reg;
      logic signed [ACC_W-1:0] sample_ext;
      logic signed [ACC_W-1:0] acc_sum;

      assign sample_ext = {{LOG2_DECIM_MAX{in_data[gi][15]}}, in_data[gi]};
      assign acc_sum    = block_start ? sample_ext : (acc_reg + sample_ext);

`ifdef ADC_DECIM_ROUND_EN
      localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'(32767);
      localparam logic signed [ACC_W:0] SAT_LO = -(ACC_W+1)'(32768);
      logic [ACC_W:0]          rnd_bias;
      logic signed [ACC_W:0]   sum_rnd;
      logic signed [ACC_W:0]   shifted;

      // Half an LSB of the output; zero when k is zero.
      assign rnd_bias = ({{ACC_W{1'b0}}, 1'b1} << k_cur) >> 1;
      assign sum_rnd  = {acc_sum[ACC_W-1], acc_sum} + $signed(rnd_bias);
      assign shifted  = sum_rnd >>> k_cur;
      assign result_w[gi] = (shifted > SAT_HI) ? 16'h7fff :
                            (shifted < SAT_LO) ? 16'h8000 : shifted[15:0];
`else
      // The mean of 16-bit samples always fits back into 16 bits.
      assign result_w[gi] = 16'(acc_sum >>> k_cur);
`endif

      // Accumulate accepted samples; a partial block is dropped when the ADC goes unready
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          acc_reg <= '0;
        end else if (!adc_ready) begin
          acc_reg <= '0;
        end else if (accept) begin
          acc_reg <= acc_sum;
        end
      end
    end
  endgenerate

  // Block sequencing, output handshake and drop accounting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      k_reg          <= '0;
      out_valid_reg  <= 1'b0;
      drop_count_reg <= '0;
    end else if (!adc_ready) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg <= ACCUM;
      if (accept) begin
        if (block_start) begin
          k_reg <= k_clip;
        end
        if (block_end) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_plus1[CNT_W-1:0];
        end
      end
      if (load_out) begin
        out_valid_reg <= 1'b1;
      end else if (block_end) begin
        if (drop_count_reg != '1) begin
          drop_count_reg <= drop_count_reg + 1'b1;
        end
      end else if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  // Output word register, only written when a result is accepted into it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        out_data_reg[i] <= '0;
      end
    end else if (load_out) begin
      for (int i = 0; i < 4; i++) begin
        out_data_reg[i] <= result_w[i];
      end
    end
  end

  assign out_A_data = out_data_reg[0];
  assign out_B_data = out_data_reg[1];
  assign out_C_data = out_data_reg[2];
  assign out_D_data = out_data_reg[3];
  assign out_valid  = out_valid_reg;
  assign drop_count = drop_count_reg;

endmodule
